// File: rtl/svnet_pkg.sv
// Shared definitions for the svnet FIFO width-down serializer.
package svnet_pkg;

    // Serializer control state: waiting for a wide word, or emitting its lanes.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : svnet_pkg

// File: rtl/svnet_fifo_serializer.sv
// Width-down converter: pops one wide word from an upstream FIFO read port and
// pushes its RATIO lanes one per cycle into a downstream FIFO write port.
// The last-lane push and the next pop share an edge, so back-to-back wide
// words stream out without a bubble.
module svnet_fifo_serializer
    import svnet_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RATIO     = 4,
    parameter int IN_DEPTH  = 2,
    parameter int OUT_DEPTH = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(IN_DEPTH):0]      in_used_space,
    input  logic [WIDTH*RATIO-1:0]         in_read_data,
    output logic                           in_read,
    input  logic [$clog2(OUT_DEPTH):0]     out_free_space,
    output logic                           out_write,
    output logic [WIDTH-1:0]               out_write_data,
    output logic                           busy
);

    localparam int WIDE = WIDTH * RATIO;
    localparam int LW   = $clog2(RATIO);
    localparam int IUW  = $clog2(IN_DEPTH) + 1;
    localparam int OFW  = $clog2(OUT_DEPTH) + 1;

    localparam logic [LW-1:0] LANE_ZERO = LW'(0);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

    state_e            state_q;
    state_e            state_d;
    logic [WIDE-1:0]   hold_q;
    logic [WIDE-1:0]   hold_d;
    logic [LW-1:0]     lane_q;
    logic [LW-1:0]     lane_d;
    logic [LW-1:0]     lane_idx;
    logic              in_avail;
    logic              out_room;
    logic              last_lane;

    // Space inputs are only ever tested against zero.
    assign in_avail  = (in_used_space != {IUW{1'b0}});
    assign out_room  = (out_free_space != {OFW{1'b0}});
    assign last_lane = (lane_q == LANE_LAST);
    assign busy      = (state_q == SHIFT);

    // Handshake strobes: pop when idle with data, or when the last lane leaves and more data waits.
    always_comb begin
        in_read   = 1'b0;
        out_write = 1'b0;
        case (state_q)
            IDLE: begin
                in_read   = in_avail;
                out_write = 1'b0;
            end
            SHIFT: begin
                out_write = out_room;
                in_read   = out_room & last_lane & in_avail;
            end
            default: begin
                in_read   = 1'b0;
                out_write = 1'b0;
            end
        endcase
    end

    // Lane selection; MSB_FIRST reverses the emission order of the lanes.
    always_comb begin
        lane_idx = lane_q;
        if (MSB_FIRST != 0) begin
            lane_idx = LANE_LAST - lane_q;
        end else begin
            lane_idx = lane_q;
        end
        out_write_data = hold_q[lane_idx*WIDTH +: WIDTH];
    end

    // Next-state logic for the holding register, lane counter and control state.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (in_avail) begin
                    hold_d  = in_read_data;
                    lane_d  = LANE_ZERO;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (!out_room) begin
                    // Downstream full: everything holds so the presented lane is stable.
                    state_d = SHIFT;
                end else if (!last_lane) begin
                    lane_d = lane_q + LANE_ONE;
                end else if (in_avail) begin
                    // Last lane leaves on the same edge the next word is popped.
                    hold_d  = in_read_data;
                    lane_d  = LANE_ZERO;
                    state_d = SHIFT;
                end else begin
                    lane_d  = LANE_ZERO;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = {WIDE{1'b0}};
                lane_d  = LANE_ZERO;
            end
        endcase
    end

    // State registers; reset discards any partially emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= {WIDE{1'b0}};
            lane_q  <= LANE_ZERO;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            lane_q  <= lane_d;
        end
    end

    // Never pop an empty upstream FIFO.
    a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        in_read |-> in_avail);

    // Never push into a full downstream FIFO.
    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        out_write |-> out_room);

endmodule : svnet_fifo_serializer

// File: doc/svnet_fifo_serializer.md
# svnet_fifo_serializer

Width-down converter between two register FIFOs. Pops one wide word of RATIO lanes from an upstream FIFO read port and pushes it lane by lane into a downstream FIFO write port. Sustains one narrow word per cycle, including across wide-word boundaries. Sits between a wide producer stage (e.g. a packed feature-map fetch) and a narrow consumer stage (e.g. a per-pixel MAC pipeline).

## Interface
Parameters:
- WIDTH, 8, narrow (output) word width in bits
- RATIO, 4, lanes per wide word; wide width = WIDTH*RATIO; must be ≥ 2
- IN_DEPTH, 2, depth of upstream FIFO; sets width of in_used_space
- OUT_DEPTH, 2, depth of downstream FIFO; sets width of out_free_space
- MSB_FIRST, 0, 0: lane 0 = bits [WIDTH-1:0] emitted first; 1: top lane emitted first

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_used_space  in  $clog2(IN_DEPTH)+1  words available upstream
- in_read_data  in  WIDTH*RATIO  upstream head word, valid when in_used_space != 0
- in_read  out  1  pop upstream head at this clock edge
- out_free_space  in  $clog2(OUT_DEPTH)+1  free slots downstream
- out_write  out  1  push out_write_data at this clock edge
- out_write_data  out  WIDTH  current lane of holding register
- busy  out  1  holding register has lanes not yet pushed

## Operation
- State: holding register hold_q (WIDTH*RATIO), lane counter lane_q ($clog2(RATIO) bits), state_q ∈ {IDLE, SHIFT}.
- IDLE: in_read = (in_used_space != 0). On a pop: hold_q ← in_read_data, lane_q ← 0, go to SHIFT.
- SHIFT: out_write = (out_free_space != 0).
  - out_write_data = lane lane_q of hold_q; lane index is reversed when MSB_FIRST = 1.
  - On a push with lane_q != RATIO-1: lane_q increments.
  - On a push with lane_q == RATIO-1 and in_used_space != 0: in_read asserted in the same cycle; hold_q reloads; lane_q ← 0; stay in SHIFT.
  - On a push with lane_q == RATIO-1 and in_used_space == 0: go to IDLE.
  - No push (downstream full): hold_q, lane_q and out_write_data are stable.
- in_read and out_write are combinational from state and the space inputs. in_read is never asserted when in_used_space == 0. out_write is never asserted when out_free_space == 0. Both are enforced by concurrent assertions disabled during reset.
- busy = (state_q == SHIFT).
- Space inputs are compared only against zero; no arithmetic on them.

## Timing
- Reset values: state IDLE, lane_q 0, hold_q 0, so in_read 0 (until in_used_space != 0), out_write 0, out_write_data 0, busy 0.
- Latency: word at upstream head in cycle t → in_read in t → first out_write in t+1 → last lane in t+RATIO if unstalled.
- Throughput: back-to-back wide words give an unbroken out_write stream; no bubble at word boundaries.
- Downstream stall of k cycles delays all later pushes by exactly k cycles.
- Reset mid-word: the partial word is discarded and its remaining lanes are never pushed. After release, the next pop starts at lane 0.
- Simultaneous in_read and out_write occur only on the last lane; both take effect on the same edge.

## Structure
- svnet_pkg: state enum (IDLE, SHIFT).
- No sub-module; single flat module.
- Lane select is a generate-free indexed part-select: hold_q[idx*WIDTH +: WIDTH], where idx = lane_q when MSB_FIRST = 0 and RATIO-1-lane_q when MSB_FIRST = 1.

## Test plan
WIDTH=8, RATIO=4 unless noted.
- Reset: hold rst_n low with in_used_space=0 → in_read=0, out_write=0, out_write_data=0x00, busy=0.
- Single word 0x44332211, out_free_space=2 → in_read for one cycle; out_write_data 0x11, 0x22, 0x33, 0x44 on four consecutive cycles; busy falls after 0x44.
- Two words 0x44332211 and 0x88776655 queued → eight consecutive pushes 0x11…0x88; second in_read in the same cycle as the 0x44 push.
- Stall: out_free_space=0 for 3 cycles while lane 1 (0x22) is presented → out_write=0, out_write_data held at 0x22; resumes with 0x22 and finishes with 0x44.
- MSB_FIRST=1 with word 0x44332211 → pushes 0x44, 0x33, 0x22, 0x11.
- Reset after the 0x22 push, then word 0xDDCCBBAA → 0x33 and 0x44 never appear; next pushes are 0xAA, 0xBB, 0xCC, 0xDD. Throughout, in_used_space=0 never coincides with in_read=1.
